// File: rtl/alto_task_scheduler.sv
// Alto microcode task scheduler.
// Registers the per-task wakeup lines, masks tasks that have just executed
// BLOCK until their request drops, and on TASK/BLOCK hands control to the
// highest-numbered ready task. Task 0 (emulator) is always ready.
module alto_task_scheduler #(
    parameter int NTASKS = 16,
    parameter int TASK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NTASKS-1:0] wakeup_i,
    input  logic [3:0]        f1_i,
    input  logic              advance_i,
    output logic [TASK_W-1:0] current_task_o,
    output logic              task_switch_o,
    output logic [NTASKS-1:0] block_o,
    output logic [NTASKS-1:0] ready_o
);

    // F1 encodings shared with the rest of the Alto microsequencer
    localparam logic [3:0] F1_TASK  = 4'd2;
    localparam logic [3:0] F1_BLOCK = 4'd3;

    logic [NTASKS-1:0] wakeup_q;
    logic [NTASKS-1:0] mask_q, mask_d;
    logic [TASK_W-1:0] currentTask_q, currentTask_d;
    logic              taskSwitch_q, taskSwitch_d;
    logic [NTASKS-1:0] block_q, block_d;

    logic [NTASKS-1:0] readyVec;
    logic [NTASKS-1:0] readyExcl;
    logic [TASK_W-1:0] nextTask;
    logic              doTask;
    logic              doBlock;

    // Effective ready vector; the emulator can never be masked off
    always_comb begin
        readyVec    = wakeup_q & ~mask_q;
        readyVec[0] = 1'b1;
    end

    // Decode TASK/BLOCK, pick the winner and compute all next-state values
    always_comb begin
        doTask  = advance_i && (f1_i == F1_TASK);
        doBlock = advance_i && (f1_i == F1_BLOCK) && (currentTask_q != '0);

        // A blocking task must not be able to re-select itself
        readyExcl = readyVec;
        if (doBlock) begin
            readyExcl[currentTask_q] = 1'b0;
        end

        // Highest index wins; bit 0 is always set so this is never empty
        nextTask = '0;
        for (int i = 0; i < NTASKS; i++) begin
            if (readyExcl[i]) begin
                nextTask = TASK_W'(i);
            end
        end

        // Mask clears wherever the request has dropped; a BLOCK set wins
        mask_d = mask_q & wakeup_q;
        if (doBlock) begin
            mask_d[currentTask_q] = 1'b1;
        end
        mask_d[0] = 1'b0;

        currentTask_d = currentTask_q;
        if (doTask || doBlock) begin
            currentTask_d = nextTask;
        end

        taskSwitch_d = (currentTask_d != currentTask_q);

        block_d = '0;
        if (doBlock) begin
            block_d[currentTask_q] = 1'b1;
        end
    end

    // State registers; reset returns control to the emulator immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wakeup_q      <= '0;
            mask_q        <= '0;
            currentTask_q <= '0;
            taskSwitch_q  <= 1'b0;
            block_q       <= '0;
        end else begin
            wakeup_q      <= wakeup_i;
            mask_q        <= mask_d;
            currentTask_q <= currentTask_d;
            taskSwitch_q  <= taskSwitch_d;
            block_q       <= block_d;
        end
    end

    assign current_task_o = currentTask_q;
    assign task_switch_o  = taskSwitch_q;
    assign block_o        = block_q;
    assign ready_o        = readyVec;

endmodule
